handshake_elastic_fifo: RTL and testbench

Elastic FIFO buffer for the dataflow handshake fabric. It sits directly downstream of constant and operator stages, for example a constant whose token feeds the CORDIC iteration datapath. It decouples producer and consumer by buffering up to DEPTH tokens. It also breaks every combinational valid/ready path between them, so constant-fed chains can be retimed without throughput loss.

---
 rtl/handshake_elastic_fifo_pkg.sv | 32 +++
 rtl/handshake_elastic_fifo_if.sv | 22 ++
 rtl/handshake_elastic_fifo_storage.sv | 31 +++
 rtl/handshake_elastic_fifo.sv | 80 ++++++++
 tb/tb_handshake_elastic_fifo.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/handshake_elastic_fifo_pkg.sv
// Shared definitions for the elastic handshake FIFO: fill-state encoding,
// width helper and the elaboration-time depth legality check.
package handshake_elastic_fifo_pkg;

   // ST_INIT exists only between reset and the first clock edge, so that
   // ins_ready stays low until the FIFO has seen a clean edge.
   typedef enum logic [1:0] {
      ST_INIT,
      ST_EMPTY,
      ST_PARTIAL,
      ST_FULL
   } fill_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((32'd1 << width) < value) width++;
      return width;
   endfunction

   function automatic bit depth_is_legal(input int unsigned depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

   function automatic fill_state_e classify(input int unsigned count,
                                            input int unsigned depth);
      if (count == 0)          return ST_EMPTY;
      else if (count == depth) return ST_FULL;
      else                     return ST_PARTIAL;
   endfunction

endpackage

// File: rtl/handshake_elastic_fifo_if.sv
// Producer/consumer handshake bundle around the elastic FIFO.
interface handshake_elastic_fifo_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] ins;
   logic                  ins_valid;
   logic                  ins_ready;
   logic [DATA_WIDTH-1:0] outs;
   logic                  outs_valid;
   logic                  outs_ready;

   // slave is the FIFO's view; master is the surrounding fabric's view
   modport slave (
      input  ins, ins_valid, outs_ready,
      output ins_ready, outs, outs_valid
   );

   modport master (
      output ins, ins_valid, outs_ready,
      input  ins_ready, outs, outs_valid
   );
endinterface

// File: rtl/handshake_elastic_fifo_storage.sv
// Token register array: one synchronous write port, one combinational read
// port, cleared on reset.
module handshake_fifo_storage
   import handshake_elastic_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned AW         = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/handshake_elastic_fifo.sv
// Elastic FIFO: buffers up to DEPTH tokens and registers both handshake
// directions so no combinational valid/ready path crosses it.
module handshake_elastic_fifo
   import handshake_elastic_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input logic                     clk,
   input logic                     rst,
   handshake_elastic_fifo_if.slave hs
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   if (!depth_is_legal(DEPTH)) begin : g_depth_check
      $error("handshake_elastic_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   fill_state_e           r_state;
   logic [CW-1:0]         w_count_nxt;
   logic                  w_ins_ready;
   logic                  w_outs_valid;
   logic                  w_push;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_rdata;

   // Handshake outputs decode purely from registered state.
   assign w_ins_ready  = (r_state == ST_EMPTY)   || (r_state == ST_PARTIAL);
   assign w_outs_valid = (r_state == ST_PARTIAL) || (r_state == ST_FULL);

   assign w_push = hs.ins_valid && w_ins_ready;
   assign w_pop  = w_outs_valid && hs.outs_ready;

   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_state  <= ST_INIT;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_state <= classify(32'(w_count_nxt), DEPTH);
      end
   end

   handshake_fifo_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_storage (
      .clk   (clk),
      .rst   (rst),
      .we    (w_push),
      .waddr (r_wr_ptr),
      .wdata (hs.ins),
      .raddr (r_rd_ptr),
      .rdata (w_rdata)
   );

   assign hs.outs       = w_rdata;
   assign hs.ins_ready  = w_ins_ready;
   assign hs.outs_valid = w_outs_valid;

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Bench for handshake_elastic_fifo: directed vector table plus scoreboarded
// multi-cycle sequences (throughput, random handshakes, mid-stream reset).
module tb_handshake_elastic_fifo;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;

   logic clk;
   logic rst_n;

   handshake_elastic_fifo_if #(.DATA_WIDTH(DW)) hs ();

   handshake_elastic_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst_n),
      .hs  (hs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          iv;
      logic [DW-1:0] din;
      logic          ordy;
      logic          e_ir;
      logic          e_ov;
      logic          chk_outs;
      logic [DW-1:0] e_outs;
   } vec_t;

   vec_t vecs [12];

   int n_pass  = 0;
   int n_total = 0;

   logic [DW-1:0] q [$];
   int            dut_pops;
   int            pushed;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Called at posedge+1 with inputs already driven; checks against the
   // queue model just before the edge, then advances the model.
   task automatic tick(input string tag);
      logic m_push;
      logic m_pop;
      #3;
      chk({tag, "_outs_valid"}, 32'(hs.outs_valid), 32'(q.size() != 0));
      chk({tag, "_ins_ready"},  32'(hs.ins_ready),  32'(q.size() != DEPTH));
      m_push = hs.ins_valid && (q.size() < DEPTH);
      m_pop  = hs.outs_ready && (q.size() > 0);
      if (m_pop) chk({tag, "_outs"}, hs.outs, q[0]);
      if (hs.outs_valid && hs.outs_ready) dut_pops++;
      @(posedge clk);
      #1;
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
         q.push_back(hs.ins);
         pushed++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //        iv    din        ordy  e_ir  e_ov  chk   e_outs
      vecs[0]  = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00};
      vecs[1]  = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10};
      vecs[2]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10};
      vecs[3]  = '{1'b1, 32'h12, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10};
      vecs[4]  = '{1'b1, 32'h13, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10};
      vecs[5]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10};
      vecs[6]  = '{1'b0, 32'h14, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11};
      vecs[7]  = '{1'b0, 32'h14, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12};
      vecs[8]  = '{1'b0, 32'h14, 1'b1, 1'b1, 1'b1, 1'b1, 32'h13};
      vecs[9]  = '{1'b0, 32'h14, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00};
      vecs[10] = '{1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 1'b1, 32'h20};
      vecs[11] = '{1'b0, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00};

      dut_pops = 0;
      pushed   = 0;

      // Reset held for 3 cycles with a token offered upstream
      rst_n         = 1'b0;
      hs.ins_valid  = 1'b1;
      hs.ins        = 32'h10;
      hs.outs_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_ins_ready",  32'(hs.ins_ready),  32'd0);
         chk("rst_outs_valid", 32'(hs.outs_valid), 32'd0);
         chk("rst_outs",       hs.outs,            32'd0);
      end
      rst_n = 1'b1;

      // Release, fill to FULL, hold 5th token, drain, empty-push latency
      for (int i = 0; i < 12; i++) begin
         hs.ins_valid  = vecs[i].iv;
         hs.ins        = vecs[i].din;
         hs.outs_ready = vecs[i].ordy;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_ins_ready", i),  32'(hs.ins_ready),  32'(vecs[i].e_ir));
         chk($sformatf("vec%0d_outs_valid", i), 32'(hs.outs_valid), 32'(vecs[i].e_ov));
         if (vecs[i].chk_outs) chk($sformatf("vec%0d_outs", i), hs.outs, vecs[i].e_outs);
      end

      // Sustained throughput: one pop per cycle after the first fill cycle
      dut_pops      = 0;
      hs.ins_valid  = 1'b1;
      hs.outs_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         hs.ins = 32'h100 + 32'(i);
         tick("thru");
      end
      chk("thru_pop_count", 32'(dut_pops), 32'd99);

      // Random 50% valid / 50% ready
      pushed = 0;
      for (int cyc = 0; cyc < 60000 && pushed < 10000; cyc++) begin
         hs.ins_valid  = 1'($urandom_range(1));
         hs.outs_ready = 1'($urandom_range(1));
         hs.ins        = $urandom;
         tick("rand");
      end
      chk("rand_token_budget", 32'(pushed), 32'd10000);
      hs.ins_valid  = 1'b0;
      hs.outs_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) tick("rand_drain");

      // Reset mid-stream with 3 tokens buffered
      hs.outs_ready = 1'b0;
      hs.ins_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         hs.ins = 32'h31 + 32'(i);
         tick("mid_fill");
      end
      hs.ins_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs_valid", 32'(hs.outs_valid), 32'd0);
      chk("mid_rst_ins_ready",  32'(hs.ins_ready),  32'd0);
      chk("mid_rst_outs",       hs.outs,            32'd0);
      q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_release_ins_ready",  32'(hs.ins_ready),  32'd1);
      chk("mid_release_outs_valid", 32'(hs.outs_valid), 32'd0);
      hs.ins_valid = 1'b1;
      hs.ins       = 32'h55;
      tick("mid_push");
      chk("mid_first_token", hs.outs, 32'h55);
      hs.ins = 32'h56;
      tick("mid_push");
      hs.ins_valid  = 1'b0;
      hs.outs_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick("mid_drain");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
